// File: rtl/sha_msg_padder_if.sv
// Message-byte stream, block-write bus and block handshake for sha_msg_padder.
//   master: drives MEM_READY, IN_VALID/IN_DATA/IN_LAST and BLOCK_ACK; observes the rest
//   slave : the padder; returns IN_READY, WR_EN/WR_ADDR/WR_DATA, BLOCK_DONE, MSG_DONE
interface sha_msg_padder_if #(
  parameter int unsigned ADDR_W = 6
) ();
  logic              MEM_READY;
  logic              IN_VALID;
  logic [7:0]        IN_DATA;
  logic              IN_LAST;
  logic              IN_READY;
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [31:0]       WR_DATA;
  logic              BLOCK_DONE;
  logic              MSG_DONE;
  logic              BLOCK_ACK;

  modport master (
    output MEM_READY, IN_VALID, IN_DATA, IN_LAST, BLOCK_ACK,
    input  IN_READY, WR_EN, WR_ADDR, WR_DATA, BLOCK_DONE, MSG_DONE
  );

  modport slave (
    input  MEM_READY, IN_VALID, IN_DATA, IN_LAST, BLOCK_ACK,
    output IN_READY, WR_EN, WR_ADDR, WR_DATA, BLOCK_DONE, MSG_DONE
  );
endinterface

// File: rtl/sha_msg_padder.sv
// SHA-256 message padder. Packs an incoming byte stream into big-endian 32-bit
// words, appends the 0x80 marker, zero fill and the 64-bit bit length, and
// writes each 512-bit block as 16 words at BASE_ADDR+0..15. After word 15 it
// pulses BLOCK_DONE (plus MSG_DONE on the final block) and waits for BLOCK_ACK.
//   CLK, RST : rising-edge clock, synchronous active-high reset
//   bus      : sha_msg_padder_if.slave (byte stream in, word writes out, handshake)
module sha_msg_padder #(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_W    = 6
) (
  input logic             CLK,
  input logic             RST,
  sha_msg_padder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DATA, PAD, LEN_HI, LEN_LO, WAIT_ACK} state_t;
  typedef enum logic [1:0] {RES_DATA, RES_PAD, RES_IDLE} resume_t;

  state_t      state, state_nxt;
  resume_t     resume, resume_nxt;

  logic [3:0]  idx;
  logic [1:0]  lane;
  logic [60:0] cnt;
  logic [23:0] pack;
  logic        marker_done;

  logic [3:0]  wr_idx;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        len_lo_q;
  logic        block_done;
  logic        msg_done;

  logic        accept;
  logic        issue;
  logic        issue_len_lo;
  logic        marker_set;
  logic [31:0] issue_word;
  logic [63:0] len_bits;

  assign len_bits = {cnt, 3'b000};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      resume <= RES_DATA;
    end else begin
      state  <= state_nxt;
      resume <= resume_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    resume_nxt = resume;
    unique case (state)
      IDLE:
        if (bus.MEM_READY) state_nxt = DATA;
      DATA:
        if (issue) begin
          if (bus.IN_LAST) begin
            resume_nxt = RES_PAD;
            if (idx == 4'd15)                     state_nxt = WAIT_ACK;
            else if (idx == 4'd13 && lane != 2'd3) state_nxt = LEN_HI;
            else                                  state_nxt = PAD;
          end else begin
            resume_nxt = RES_DATA;
            if (idx == 4'd15) state_nxt = WAIT_ACK;
          end
        end
      PAD:
        if (idx == 4'd13)      state_nxt = LEN_HI;
        else if (idx == 4'd15) state_nxt = WAIT_ACK;
      LEN_HI:
        state_nxt = LEN_LO;
      LEN_LO: begin
        state_nxt  = WAIT_ACK;
        resume_nxt = RES_IDLE;
      end
      WAIT_ACK:
        if (bus.BLOCK_ACK) begin
          unique case (resume)
            RES_DATA: state_nxt = DATA;
            RES_PAD:  state_nxt = PAD;
            default:  state_nxt = IDLE;
          endcase
        end
      default:
        state_nxt = IDLE;
    endcase
  end

  // Every write is registered, so the word is chosen one cycle ahead: the
  // IN_LAST byte and the resuming BLOCK_ACK each launch the next write directly.
  always_comb begin
    accept       = (state == DATA) && bus.IN_VALID;
    issue        = 1'b0;
    issue_len_lo = 1'b0;
    marker_set   = 1'b0;
    issue_word   = '0;
    unique case (state)
      DATA:
        if (accept && (lane == 2'd3 || bus.IN_LAST)) begin
          issue = 1'b1;
          if (!bus.IN_LAST || lane == 2'd3) begin
            issue_word = {pack, bus.IN_DATA};
          end else begin
            marker_set = 1'b1;
            unique case (lane)
              2'd0:    issue_word = {bus.IN_DATA, 8'h80, 16'h0000};
              2'd1:    issue_word = {pack[7:0], bus.IN_DATA, 8'h80, 8'h00};
              default: issue_word = {pack[15:0], bus.IN_DATA, 8'h80};
            endcase
          end
        end
      PAD: begin
        issue      = 1'b1;
        marker_set = 1'b1;
        issue_word = marker_done ? 32'h0000_0000 : 32'h8000_0000;
      end
      LEN_HI: begin
        issue      = 1'b1;
        issue_word = len_bits[63:32];
      end
      LEN_LO: begin
        issue        = 1'b1;
        issue_len_lo = 1'b1;
        issue_word   = len_bits[31:0];
      end
      WAIT_ACK:
        if (bus.BLOCK_ACK && resume == RES_PAD) begin
          issue      = 1'b1;
          marker_set = 1'b1;
          issue_word = marker_done ? 32'h0000_0000 : 32'h8000_0000;
        end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx         <= '0;
      lane        <= '0;
      cnt         <= '0;
      pack        <= '0;
      marker_done <= 1'b0;
      wr_en       <= 1'b0;
      wr_idx      <= '0;
      wr_data     <= '0;
      len_lo_q    <= 1'b0;
      block_done  <= 1'b0;
      msg_done    <= 1'b0;
    end else begin
      if (accept) begin
        cnt  <= cnt + 61'd1;
        pack <= {pack[15:0], bus.IN_DATA};
        lane <= bus.IN_LAST ? 2'd0 : lane + 2'd1;
      end
      if (issue) begin
        idx     <= idx + 4'd1;
        wr_idx  <= idx;
        wr_data <= issue_word;
      end
      if (marker_set) marker_done <= 1'b1;
      if (state == WAIT_ACK && bus.BLOCK_ACK && resume == RES_IDLE) begin
        cnt         <= '0;
        marker_done <= 1'b0;
      end
      wr_en      <= issue;
      len_lo_q   <= issue_len_lo;
      block_done <= wr_en && (wr_idx == 4'd15);
      msg_done   <= wr_en && len_lo_q;
    end
  end

  assign bus.IN_READY   = (state == DATA);
  assign bus.WR_EN      = wr_en;
  assign bus.WR_ADDR    = ADDR_W'(BASE_ADDR) + ADDR_W'(wr_idx);
  assign bus.WR_DATA    = wr_data;
  assign bus.BLOCK_DONE = block_done;
  assign bus.MSG_DONE   = msg_done;

endmodule

// File: tb/tb_sha_msg_padder.sv
module tb_sha_msg_padder;
  localparam int unsigned AW   = 6;
  localparam int unsigned BASE = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha_msg_padder_if #(.ADDR_W(AW)) bus ();

  sha_msg_padder #(.BASE_ADDR(BASE), .ADDR_W(AW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stimulus / reference (written by the main sequence only)
  logic [7:0]    msg[$];
  logic [AW+31:0] exp_w[$];
  logic [AW+31:0] abc_w[$];
  int  ack_delay     = 0;
  bit  gap_en        = 1'b0;
  bit  suppress_last = 1'b0;
  int  last_cyc      = 0;
  int  clr_req       = 0;

  // observations (written by the monitor only)
  logic [AW+31:0] wr_q[$];
  int  wr_cyc_q[$];
  int  bd_q[$];
  logic md_q[$];
  int  ack_q[$];
  bit  pending       = 1'b0;
  int  ack_cnt       = 0;
  bit  ack_final     = 1'b0;
  bit  msg_done_seen = 1'b0;
  int  msg_done_cyc  = 0;
  int  stray_md      = 0;
  int  wait_viol     = 0;
  int  resume_viol   = 0;
  int  clr_seen      = 0;

  // Monitor and block-ack responder, sampling on the falling edge.
  initial begin
    bus.BLOCK_ACK = 1'b0;
    forever begin
      @(negedge clk);
      if (clr_req != clr_seen) begin
        clr_seen = clr_req;
        wr_q.delete(); wr_cyc_q.delete(); bd_q.delete(); md_q.delete(); ack_q.delete();
        msg_done_seen = 1'b0; stray_md = 0; wait_viol = 0; resume_viol = 0;
      end
      if (bus.WR_EN) begin
        wr_q.push_back({bus.WR_ADDR, bus.WR_DATA});
        wr_cyc_q.push_back(cyc);
      end
      if ((pending || bus.BLOCK_DONE) && (bus.IN_READY || bus.WR_EN)) wait_viol++;
      if (bus.BLOCK_ACK && !ack_final && !(bus.IN_READY || bus.WR_EN)) resume_viol++;
      if (bus.MSG_DONE && !bus.BLOCK_DONE) stray_md++;
      if (bus.BLOCK_DONE) begin
        bd_q.push_back(wr_q.size());
        md_q.push_back(bus.MSG_DONE);
        pending   = 1'b1;
        ack_cnt   = ack_delay;
        ack_final = bus.MSG_DONE;
        if (bus.MSG_DONE) begin
          msg_done_seen = 1'b1;
          msg_done_cyc  = cyc;
        end
      end
      bus.BLOCK_ACK = 1'b0;
      if (pending) begin
        if (ack_cnt == 0) begin
          bus.BLOCK_ACK = 1'b1;
          pending       = 1'b0;
          ack_q.push_back(cyc);
        end else begin
          ack_cnt--;
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed no finish, expected finish before 5ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW+31:0] get_w(input int unsigned j);
    if (j < wr_q.size()) return wr_q[j];
    return 'x;
  endfunction

  // Padded message straight from the SHA-256 padding rule.
  task automatic build_ref();
    logic [7:0]  p[$];
    logic [63:0] bl;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bl = 64'(msg.size()) << 3;
    for (int unsigned k = 0; k < 8; k++) p.push_back(bl[8*(7-k) +: 8]);
    exp_w.delete();
    for (int unsigned j = 0; j < p.size() / 4; j++)
      exp_w.push_back({AW'(BASE + (j % 16)), p[4*j], p[4*j+1], p[4*j+2], p[4*j+3]});
  endtask

  task automatic clear_obs();
    clr_req++;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic send_msg();
    int unsigned i = 0;
    int unsigned guard = 0;
    while (i < msg.size()) begin
      @(negedge clk);
      bus.IN_VALID = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.IN_DATA  = msg[i];
      bus.IN_LAST  = !suppress_last && (i == msg.size() - 1);
      if (bus.IN_VALID && bus.IN_READY) begin
        if (bus.IN_LAST) last_cyc = cyc;
        i++;
      end
      guard++;
      if (guard > 5000) break;
    end
    chk("send.accepted", 64'(i), 64'(msg.size()));
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    bus.IN_LAST  = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned g = 0;
    while (!(msg_done_seen && !pending && !bus.BLOCK_ACK) && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    chk("wait.msg_done", 64'(msg_done_seen), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_msg(input string tag);
    int unsigned nb;
    nb = exp_w.size() / 16;
    chk({tag, ".nwrites"}, 64'(wr_q.size()), 64'(exp_w.size()));
    for (int unsigned j = 0; j < exp_w.size(); j++)
      chk($sformatf("%s.w%0d", tag, j), 64'(get_w(j)), 64'(exp_w[j]));
    chk({tag, ".nblocks"}, 64'(bd_q.size()), 64'(nb));
    for (int unsigned b = 0; b < nb && b < bd_q.size(); b++) begin
      chk($sformatf("%s.bd_pos%0d", tag, b), 64'(bd_q[b]), 64'(16 * (b + 1)));
      chk($sformatf("%s.msg_done%0d", tag, b), 64'(md_q[b]), 64'(b == nb - 1));
    end
    chk({tag, ".stray_msg_done"}, 64'(stray_md), 64'd0);
    chk({tag, ".busy_in_wait"}, 64'(wait_viol), 64'd0);
    chk({tag, ".ack_turnaround"}, 64'(resume_viol), 64'd0);
    if (msg.size() <= 55)
      chk({tag, ".latency"}, 64'(msg_done_cyc - last_cyc), 64'(17 - (msg.size() - 1) / 4));
  endtask

  task automatic run_msg(input string tag);
    clear_obs();
    build_ref();
    send_msg();
    wait_done();
    check_msg(tag);
  endtask

  initial begin
    int unsigned hold_viol;
    int unsigned len;
    rst = 1'b1;
    bus.MEM_READY = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.IN_DATA   = 8'h00;
    bus.IN_LAST   = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst.in_ready",   64'(bus.IN_READY),   64'd0);
    chk("rst.wr_en",      64'(bus.WR_EN),      64'd0);
    chk("rst.wr_addr",    64'(bus.WR_ADDR),    64'(BASE));
    chk("rst.wr_data",    64'(bus.WR_DATA),    64'd0);
    chk("rst.block_done", 64'(bus.BLOCK_DONE), 64'd0);
    chk("rst.msg_done",   64'(bus.MSG_DONE),   64'd0);
    rst = 1'b0;

    // memory not ready: offered bytes must be ignored
    bus.IN_VALID = 1'b1; bus.IN_DATA = 8'h5a; bus.IN_LAST = 1'b1;
    hold_viol = 0;
    for (int unsigned c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.IN_READY || bus.WR_EN) hold_viol++;
    end
    chk("memwait.activity", 64'(hold_viol), 64'd0);
    bus.IN_VALID = 1'b0; bus.IN_LAST = 1'b0;
    bus.MEM_READY = 1'b1;

    // "abc"
    msg = {8'h61, 8'h62, 8'h63};
    ack_delay = 0;
    run_msg("abc");
    chk("abc.W0",  64'(get_w(0)),  64'({AW'(BASE),      32'h6162_6380}));
    chk("abc.W15", 64'(get_w(15)), 64'({AW'(BASE + 15), 32'h0000_0018}));
    abc_w = wr_q;

    // 55 zero bytes
    msg.delete();
    for (int unsigned i = 0; i < 55; i++) msg.push_back(8'h00);
    run_msg("z55");
    chk("z55.W13", 64'(get_w(13)), 64'({AW'(BASE + 13), 32'h0000_0080}));
    chk("z55.W15", 64'(get_w(15)), 64'({AW'(BASE + 15), 32'h0000_01B8}));

    // 56 zero bytes
    msg.push_back(8'h00);
    ack_delay = 2;
    run_msg("z56");
    chk("z56.b1W14", 64'(get_w(14)), 64'({AW'(BASE + 14), 32'h8000_0000}));
    chk("z56.b2W15", 64'(get_w(31)), 64'({AW'(BASE + 15), 32'h0000_01C0}));

    // 64 random bytes, first ack 10 cycles late
    msg.delete();
    for (int unsigned i = 0; i < 64; i++) msg.push_back(8'($urandom));
    ack_delay = 10;
    run_msg("r64");
    chk("r64.b2W0",  64'(get_w(16)), 64'({AW'(BASE),      32'h8000_0000}));
    chk("r64.b2W15", 64'(get_w(31)), 64'({AW'(BASE + 15), 32'h0000_0200}));
    if (ack_q.size() > 0 && wr_cyc_q.size() > 16)
      chk("r64.pad_after_ack", 64'(wr_cyc_q[16] - ack_q[0]), 64'd1);
    else
      chk("r64.ack_seen", 64'(ack_q.size()), 64'd2);

    // randomized messages with input gaps and varied ack delays
    gap_en = 1'b1;
    for (int unsigned r = 0; r < 8; r++) begin
      len = $urandom_range(1, 150);
      msg.delete();
      for (int unsigned i = 0; i < len; i++) msg.push_back(8'($urandom));
      ack_delay = $urandom_range(0, 4);
      run_msg($sformatf("rnd%0d_len%0d", r, len));
    end
    gap_en = 1'b0;

    // reset in the middle of a message
    msg = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    suppress_last = 1'b1;
    ack_delay = 0;
    clear_obs();
    send_msg();
    suppress_last = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.in_ready",   64'(bus.IN_READY),   64'd0);
    chk("midrst.wr_en",      64'(bus.WR_EN),      64'd0);
    chk("midrst.wr_addr",    64'(bus.WR_ADDR),    64'(BASE));
    chk("midrst.wr_data",    64'(bus.WR_DATA),    64'd0);
    chk("midrst.block_done", 64'(bus.BLOCK_DONE), 64'd0);
    chk("midrst.msg_done",   64'(bus.MSG_DONE),   64'd0);
    rst = 1'b0;
    msg = {8'h61, 8'h62, 8'h63};
    run_msg("abc2");
    for (int unsigned j = 0; j < abc_w.size(); j++)
      chk($sformatf("abc2.same_w%0d", j), 64'(get_w(j)), 64'(abc_w[j]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
